// File: rtl/lr_prod_accumulator_if.sv
// Handshake bundle between the product multiplier, the accumulator and the
// regression solve stage: product stream in, packet sum out.
`timescale 1ns/1ps

interface lr_prod_accumulator_if #(
    parameter int PROD_WIDTH = 33,
    parameter int ACC_WIDTH  = 40,
    parameter int CNT_WIDTH  = 5
);
    logic [PROD_WIDTH-1:0] s_prod;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    logic [ACC_WIDTH-1:0]  m_sum;
    logic [CNT_WIDTH-1:0]  m_count;
    logic                  m_ovf;
    logic                  m_valid;
    logic                  m_ready;

    // Accumulator side: sinks products, sources the packet result.
    modport slave (
        input  s_prod,
        input  s_valid,
        input  s_last,
        input  m_ready,
        output s_ready,
        output m_sum,
        output m_count,
        output m_ovf,
        output m_valid
    );

    // Environment side: sources products, sinks the packet result.
    modport master (
        output s_prod,
        output s_valid,
        output s_last,
        output m_ready,
        input  s_ready,
        input  m_sum,
        input  m_count,
        input  m_ovf,
        input  m_valid
    );
endinterface

// File: rtl/lr_prod_accumulator.sv
// Packet accumulator for the LR fit: sums signed products until s_last and hands
// the sum, term count and overflow flag downstream. Define LR_ACC_SAT_EN for saturating adds.
`timescale 1ns/1ps

module lr_prod_accumulator #(
    parameter int PROD_WIDTH = 33,
    parameter int ACC_WIDTH  = 40,
    parameter int CNT_WIDTH  = 5,
    parameter int MAX_TERMS  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    lr_prod_accumulator_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;

    logic [ACC_WIDTH-1:0]   acc_r;
    logic [CNT_WIDTH-1:0]   count_r;
    logic                   ovf_r;
    logic [ACC_WIDTH-1:0]   m_sum_r;
    logic [CNT_WIDTH-1:0]   m_count_r;
    logic                   m_ovf_r;
    logic                   m_valid_r;
    logic                   s_ready_r;

    logic [ACC_WIDTH-1:0]   acc_nxt_s;
    logic [CNT_WIDTH-1:0]   count_nxt_s;
    logic                   ovf_nxt_s;
    logic [ACC_WIDTH-1:0]   m_sum_nxt_s;
    logic [CNT_WIDTH-1:0]   m_count_nxt_s;
    logic                   m_ovf_nxt_s;
    logic                   m_valid_nxt_s;

    logic [ACC_WIDTH-1:0]   add_res_s;
    logic                   add_ovf_s;
    logic                   overrun_s;
    logic                   accept_s;
    logic [ACC_WIDTH-1:0]   step_acc_s;
    logic [CNT_WIDTH-1:0]   step_cnt_s;
    logic                   step_ovf_s;

`ifdef LR_ACC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // One guard bit above the accumulator: a mismatch with the sign bit means the
    // true sum left the representable range.
    function automatic logic sum_ovf(input logic [ACC_WIDTH:0] s);
        return s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
    endfunction

    function automatic logic [ACC_WIDTH-1:0] clamp_sum(input logic [ACC_WIDTH:0] s);
        logic [ACC_WIDTH-1:0] r;
        if (sum_ovf(s)) begin
            r = s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            r = s[ACC_WIDTH-1:0];
        end
        return r;
    endfunction

    logic [ACC_WIDTH:0] sum_ext_s;

    assign sum_ext_s = {acc_r[ACC_WIDTH-1], acc_r} + (ACC_WIDTH+1)'($signed(bus.s_prod));
    assign add_res_s = clamp_sum(sum_ext_s);
    assign add_ovf_s = sum_ovf(sum_ext_s);
`else
    logic [ACC_WIDTH-1:0] sum_wrap_s;

    assign sum_wrap_s = acc_r + ACC_WIDTH'($signed(bus.s_prod));
    assign add_res_s  = sum_wrap_s;
    assign add_ovf_s  = 1'b0;
`endif

    assign accept_s  = bus.s_valid & s_ready_r;
    assign overrun_s = (count_r == CNT_WIDTH'(MAX_TERMS));

    // acc/count/ovf are zero whenever IDLE, so the same step serves the first term.
    assign step_acc_s = overrun_s ? acc_r   : add_res_s;
    assign step_cnt_s = overrun_s ? count_r : count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    assign step_ovf_s = ovf_r | overrun_s | add_ovf_s;

    // Next-state and next-register decode for the packet FSM.
    always_comb begin
        state_nxt_s   = state_r;
        acc_nxt_s     = acc_r;
        count_nxt_s   = count_r;
        ovf_nxt_s     = ovf_r;
        m_sum_nxt_s   = m_sum_r;
        m_count_nxt_s = m_count_r;
        m_ovf_nxt_s   = m_ovf_r;
        m_valid_nxt_s = m_valid_r;
        case (state_r)
            IDLE, ACCUM: begin
                if (accept_s) begin
                    if (bus.s_last) begin
                        m_sum_nxt_s   = step_acc_s;
                        m_count_nxt_s = step_cnt_s;
                        m_ovf_nxt_s   = step_ovf_s;
                        m_valid_nxt_s = 1'b1;
                        state_nxt_s   = HOLD;
                    end else begin
                        acc_nxt_s   = step_acc_s;
                        count_nxt_s = step_cnt_s;
                        ovf_nxt_s   = step_ovf_s;
                        state_nxt_s = ACCUM;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    m_valid_nxt_s = 1'b0;
                    acc_nxt_s     = {ACC_WIDTH{1'b0}};
                    count_nxt_s   = {CNT_WIDTH{1'b0}};
                    ovf_nxt_s     = 1'b0;
                    state_nxt_s   = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                acc_nxt_s     = {ACC_WIDTH{1'b0}};
                count_nxt_s   = {CNT_WIDTH{1'b0}};
                ovf_nxt_s     = 1'b0;
                m_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state register; s_ready is registered from the next state.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_r   <= IDLE;
            s_ready_r <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            s_ready_r <= (state_nxt_s != HOLD);
        end
    end

    // Accumulator and output registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_r     <= {ACC_WIDTH{1'b0}};
            count_r   <= {CNT_WIDTH{1'b0}};
            ovf_r     <= 1'b0;
            m_sum_r   <= {ACC_WIDTH{1'b0}};
            m_count_r <= {CNT_WIDTH{1'b0}};
            m_ovf_r   <= 1'b0;
            m_valid_r <= 1'b0;
        end else begin
            acc_r     <= acc_nxt_s;
            count_r   <= count_nxt_s;
            ovf_r     <= ovf_nxt_s;
            m_sum_r   <= m_sum_nxt_s;
            m_count_r <= m_count_nxt_s;
            m_ovf_r   <= m_ovf_nxt_s;
            m_valid_r <= m_valid_nxt_s;
        end
    end

    assign bus.s_ready = s_ready_r;
    assign bus.m_sum   = m_sum_r;
    assign bus.m_count = m_count_r;
    assign bus.m_ovf   = m_ovf_r;
    assign bus.m_valid = m_valid_r;

endmodule

// File: tb/tb_lr_prod_accumulator.sv
// Scoreboard bench for lr_prod_accumulator: a default instance plus a narrow-accumulator
// instance (36-bit acc, 63 terms) so that 40 large products actually leave the range.
`timescale 1ns/1ps

module tb_lr_prod_accumulator;

    localparam int PW  = 33;
    localparam int AW  = 40;
    localparam int CW  = 5;
    localparam int MT  = 16;
    localparam int SAW = 36;
    localparam int SCW = 6;
    localparam int SMT = 63;
`ifdef LR_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct {
        longint sum;
        int     count;
        bit     ovf;
    } exp_t;
    typedef longint lq_t[$];

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    exp_t sexp_q[$];

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    lr_prod_accumulator_if #(.PROD_WIDTH(PW), .ACC_WIDTH(AW),  .CNT_WIDTH(CW))  bus ();
    lr_prod_accumulator_if #(.PROD_WIDTH(PW), .ACC_WIDTH(SAW), .CNT_WIDTH(SCW)) sbus ();

    lr_prod_accumulator #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .CNT_WIDTH(CW), .MAX_TERMS(MT)) dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus     (bus)
    );

    lr_prod_accumulator #(.PROD_WIDTH(PW), .ACC_WIDTH(SAW), .CNT_WIDTH(SCW), .MAX_TERMS(SMT)) dut_s (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus     (sbus)
    );

    // Reference: exact integer sum, then clamp or wrap into accw signed bits.
    function automatic exp_t model_pkt(input lq_t p, input int accw, input int maxt, input bit sat);
        exp_t   e;
        longint acc  = 0;
        longint s;
        longint m    = longint'(1) << accw;
        longint maxv = (longint'(1) << (accw - 1)) - 1;
        longint minv = -(longint'(1) << (accw - 1));
        int     cnt  = 0;
        bit     ovf  = 1'b0;
        foreach (p[i]) begin
            if (cnt == maxt) begin
                ovf = 1'b1;
            end else begin
                s = acc + p[i];
                if (s > maxv || s < minv) begin
                    if (sat) begin
                        ovf = 1'b1;
                        s   = (s > maxv) ? maxv : minv;
                    end else begin
                        s = ((s % m) + m) % m;
                        if (s > maxv) s = s - m;
                    end
                end
                acc = s;
                cnt++;
            end
        end
        e.sum   = acc;
        e.count = cnt;
        e.ovf   = ovf;
        return e;
    endfunction

    always @(negedge ap_clk) begin : mon_main
        exp_t e;
        if (ap_rst_n && bus.m_valid && bus.m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL main_unexpected: got sum=%0d with no packet pending", $signed(bus.m_sum));
            end else begin
                e = exp_q.pop_front();
                if (longint'($signed(bus.m_sum)) !== e.sum || int'(bus.m_count) !== e.count || bus.m_ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL main_result: got sum=%0d count=%0d ovf=%0b want sum=%0d count=%0d ovf=%0b",
                             $signed(bus.m_sum), bus.m_count, bus.m_ovf, e.sum, e.count, e.ovf);
                end
            end
        end
    end

    always @(negedge ap_clk) begin : mon_sat
        exp_t e;
        if (ap_rst_n && sbus.m_valid && sbus.m_ready) begin
            checks++;
            if (sexp_q.size() == 0) begin
                failures++;
                $display("FAIL sat_unexpected: got sum=%0d with no packet pending", $signed(sbus.m_sum));
            end else begin
                e = sexp_q.pop_front();
                if (longint'($signed(sbus.m_sum)) !== e.sum || int'(sbus.m_count) !== e.count || sbus.m_ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL sat_result: got sum=%0d count=%0d ovf=%0b want sum=%0d count=%0d ovf=%0b",
                             $signed(sbus.m_sum), sbus.m_count, sbus.m_ovf, e.sum, e.count, e.ovf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // Drive one product per accepted beat; returns #1 after the final accepting edge.
    task automatic send_main(input lq_t p, input bit close);
        int n_wait;
        if (close) exp_q.push_back(model_pkt(p, AW, MT, SAT_EN));
        foreach (p[i]) begin
            bus.s_prod  = p[i][PW-1:0];
            bus.s_valid = 1'b1;
            bus.s_last  = close && (i == p.size() - 1);
            n_wait = 0;
            @(negedge ap_clk);
            while (!bus.s_ready && n_wait < 50) begin
                @(negedge ap_clk);
                n_wait++;
            end
            if (n_wait >= 50) begin
                checks++;
                failures++;
                $display("FAIL main_accept_timeout: got s_ready=%0b want 1", bus.s_ready);
            end
            @(posedge ap_clk);
            #1;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_sat(input lq_t p);
        int n_wait;
        sexp_q.push_back(model_pkt(p, SAW, SMT, SAT_EN));
        foreach (p[i]) begin
            sbus.s_prod  = p[i][PW-1:0];
            sbus.s_valid = 1'b1;
            sbus.s_last  = (i == p.size() - 1);
            n_wait = 0;
            @(negedge ap_clk);
            while (!sbus.s_ready && n_wait < 50) begin
                @(negedge ap_clk);
                n_wait++;
            end
            if (n_wait >= 50) begin
                checks++;
                failures++;
                $display("FAIL sat_accept_timeout: got s_ready=%0b want 1", sbus.s_ready);
            end
            @(posedge ap_clk);
            #1;
        end
        sbus.s_valid = 1'b0;
        sbus.s_last  = 1'b0;
    endtask

    task automatic test_reset();
        bus.s_prod = '0;  bus.s_valid = 1'b0;  bus.s_last = 1'b0;  bus.m_ready = 1'b1;
        sbus.s_prod = '0; sbus.s_valid = 1'b0; sbus.s_last = 1'b0; sbus.m_ready = 1'b1;
        ap_rst_n = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        checks++;
        if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready: got %0b want 1", bus.s_ready); end
        checks++;
        if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %0b want 0", bus.m_valid); end
        checks++;
        if (bus.m_sum !== 40'd0 || bus.m_count !== 5'd0 || bus.m_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got sum=%0d count=%0d ovf=%0b want 0 0 0", bus.m_sum, bus.m_count, bus.m_ovf);
        end
    endtask

    task automatic test_basic();
        lq_t q;
        bus.m_ready = 1'b1;
        q.push_back(64'sd100); q.push_back(-64'sd30); q.push_back(64'sd7);
        send_main(q, 1'b1);
        checks++;
        if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL basic_latency: got m_valid=%0b want 1", bus.m_valid); end
        checks++;
        if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL basic_hold_ready: got s_ready=%0b want 0", bus.s_ready); end
        @(posedge ap_clk);
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_one_cycle: got m_valid=%0b s_ready=%0b want 0 1", bus.m_valid, bus.s_ready);
        end
    endtask

    task automatic test_single();
        lq_t q;
        bus.m_ready = 1'b0;
        q.push_back(-64'sd5);
        send_main(q, 1'b1);
        checks++;
        if (bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_latency: got m_valid=%0b s_ready=%0b want 1 0", bus.m_valid, bus.s_ready);
        end
        repeat (3) @(negedge ap_clk);
        checks++;
        if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL single_stall: got s_ready=%0b want 0", bus.s_ready); end
        bus.m_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_release: got m_valid=%0b s_ready=%0b want 0 1", bus.m_valid, bus.s_ready);
        end
    endtask

    task automatic test_backpressure();
        lq_t q;
        bus.m_ready = 1'b0;
        q.push_back(64'sd100); q.push_back(-64'sd30); q.push_back(64'sd7);
        send_main(q, 1'b1);
        bus.s_prod  = 33'd999;
        bus.s_valid = 1'b1;
        bus.s_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            checks++;
            if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1 || bus.m_sum !== 40'd77 ||
                bus.m_count !== 5'd3 || bus.m_ovf !== 1'b0) begin
                failures++;
                $display("FAIL bp_stable: cycle %0d got s_ready=%0b m_valid=%0b sum=%0d count=%0d ovf=%0b want 0 1 77 3 0",
                         i, bus.s_ready, bus.m_valid, $signed(bus.m_sum), bus.m_count, bus.m_ovf);
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        q.delete();
        q.push_back(64'sd4); q.push_back(64'sd5);
        send_main(q, 1'b1);
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_overrun();
        lq_t q;
        int  c0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 18; i++) q.push_back(64'sd1);
        c0 = cyc;
        send_main(q, 1'b1);
        checks++;
        if (cyc - c0 !== 18) begin failures++; $display("FAIL overrun_accept: got %0d cycles want 18", cyc - c0); end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_reset_mid();
        lq_t q;
        bus.m_ready = 1'b1;
        q.push_back(64'sd3); q.push_back(64'sd3);
        send_main(q, 1'b0);
        #3;
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.m_sum !== 40'd0 || bus.m_count !== 5'd0 ||
            bus.m_ovf !== 1'b0 || bus.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_outputs: got valid=%0b sum=%0d count=%0d ovf=%0b s_ready=%0b want 0 0 0 0 1",
                     bus.m_valid, bus.m_sum, bus.m_count, bus.m_ovf, bus.s_ready);
        end
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk);
            checks++;
            if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL midreset_no_valid: got %0b want 0", bus.m_valid); end
        end
        @(posedge ap_clk);
        #1;
        q.delete();
        q.push_back(64'sd4); q.push_back(64'sd4);
        send_main(q, 1'b1);
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_saturation();
        lq_t q;
        sbus.m_ready = 1'b1;
        for (int i = 0; i < 40; i++) q.push_back(64'sd4294967295);
        send_sat(q);
        @(posedge ap_clk);
        #1;
        q.delete();
        for (int i = 0; i < 40; i++) q.push_back(-64'sd4294967296);
        send_sat(q);
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_saturation();
        repeat (4) @(posedge ap_clk);
        #1;
        checks++;
        if (exp_q.size() !== 0 || sexp_q.size() !== 0) begin
            failures++;
            $display("FAIL drain: got pending main=%0d sat=%0d want 0 0", exp_q.size(), sexp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
